cpu_clkgen_multi: RTL and testbench
===================================

Name: cpu_clkgen_multi

Overview:
- Parametrised successor to the fixed divide-by-15 CPU clock and reset stretcher in the 8088 top level.
- Derives CPU_CLK from the fast bus clock using one of two compile-time divide ratios, each with its own high time. The active ratio is selected at run time and switches glitch-free at a period boundary.
- Stretches reset for a programmable number of CPU clocks while the clock keeps running.
- Emits single-cycle rise/fall tick strobes in the aclk domain so that downstream logic samples bus pins as clock enables instead of clocking on CPU_CLK.

Parameters:
- DIV_A, 15, ratio A period in aclk cycles (≥2).
- HIGH_A, 5, ratio A high-phase length (1..DIV_A-1).
- DIV_B, 9, ratio B period (≥2).
- HIGH_B, 3, ratio B high-phase length (1..DIV_B-1).
- RESET_HOLD, 255, CPU clock rising edges for which CPU_RESET stays asserted after the request drops (≥1).
- CNT_W, 5, phase counter width; must satisfy 2^CNT_W ≥ max(DIV_A, DIV_B).

Ports:
- aclk  in  1  fast bus clock (83 MHz domain).
- aresetn  in  1  async active-low reset.
- cpu_reset_req  in  1  sync active-high reset request (e.g. PERIPHERAL reset controller).
- div_sel  in  1  0 = ratio A, 1 = ratio B; level, sampled at period boundary.
- CPU_CLK  out  1  registered CPU clock to pin.
- CPU_RESET  out  1  registered stretched reset to pin.
- clk_rise_tick  out  1  one aclk pulse coincident with CPU_CLK 0→1.
- clk_fall_tick  out  1  one aclk pulse coincident with CPU_CLK 1→0.
- div_active  out  1  ratio currently in effect.

Behaviour:
- Interface: one clock, aclk. Reset aresetn is asynchronous and active-low.
- Async reset values: phase counter p=0, div_active=0, CPU_CLK=0, CPU_RESET=1, hold counter=0, both ticks 0.
- Per aclk cycle:
  - If p==DIV_act-1: p←0 and div_active←div_sel. Otherwise p←p+1.
  - CPU_CLK←(p<HIGH_act).
  - clk_rise_tick←(p==0).
  - clk_fall_tick←(p==HIGH_act).
- Resulting waveform: CPU_CLK is high HIGH_act cycles and low DIV_act-HIGH_act cycles. Its first rising edge is at the first aclk edge after aresetn releases.
- Ratio switch:
  - Takes effect only at wrap, so the last low phase of the old ratio always completes.
  - No runt pulse.
  - div_sel toggling mid-period has no effect until the wrap.
  - div_active updates on the same edge p returns to 0.
- Reset stretch:
  - While cpu_reset_req=1: hold←0 and CPU_RESET←1. The clock keeps running; the 8088 needs clocks during reset.
  - While cpu_reset_req=0 and CPU_RESET=1: hold increments on each aclk cycle where clk_rise_tick=1.
  - On the cycle with clk_rise_tick=1 and hold==RESET_HOLD-1: CPU_RESET←0, one aclk after the CPU_CLK rising edge, inside the high phase.
  - Once CPU_RESET=0 the hold counter freezes.
- cpu_reset_req re-asserted after release: CPU_RESET←1 on the next edge and hold clears. Phase and ratio are unaffected.
- aresetn mid-period: everything returns to reset values immediately. div_active returns to A regardless of div_sel.
- Elaboration must fail ($error) on:
  - HIGH≥DIV;
  - DIV<2;
  - RESET_HOLD<1;
  - CNT_W too small.
- Hold counter width is $clog2(RESET_HOLD+1).

Optional Feature:
- Macro: CPU_CLKGEN_STEP_EN.
- With the macro:
  - Adds input clk_hold (1 bit). When clk_hold=1 at a cycle where p==HIGH_act, p freezes at HIGH_act and CPU_CLK stays low.
  - While frozen, no ticks are generated and the ratio does not switch.
  - When clk_hold drops, counting resumes with the next increment. The low phase is lengthened only; the high phase is never truncated.
  - cpu_reset_req still clears hold/CPU_RESET while frozen.
- Without the macro: port absent; behaves as clk_hold=0.

Test Plan:
- Defaults, div_sel=0, release aresetn → CPU_CLK pattern 5 high / 10 low; clk_rise_tick period 15; clk_fall_tick 5 cycles after each rise tick.
- RESET_HOLD=4, cpu_reset_req pulsed 20 cycles then low → CPU_RESET stays 1 across exactly 4 further rise ticks and drops 1 aclk after the 4th. Re-pulse cpu_reset_req → CPU_RESET back to 1 next edge.
- Toggle div_sel 0→1 at p=7 → remaining period stays ratio A (8 more cycles); next period is 3 high / 6 low; div_active rises on the wrap edge; no high pulse shorter than 3 cycles anywhere.
- Toggle div_sel 1→0→1 within one ratio-B period → no change in waveform; div_active stays 1.
- Assert aresetn low mid high-phase (p=2) → CPU_CLK=0, CPU_RESET=1, div_active=0 immediately. After release the first rise tick occurs on the first edge.
- CPU_CLKGEN_STEP_EN defined: hold clk_hold=1 for 40 cycles from p=3 → CPU_CLK high phase completes 5 cycles, then low for 10+(40-2) style extension with no ticks; resumes to normal 15-cycle period after release; cpu_reset_req during freeze sets CPU_RESET=1.

Source files
------------

// File: rtl/cpu_clkgen_multi.sv
`timescale 1ns/1ps
// Dual-ratio CPU clock generator with reset stretcher and aclk-domain rise/fall ticks.
// Optional clock-step hold input is enabled by defining CPU_CLKGEN_STEP_EN.
module cpu_clkgen_multi #(
  parameter int DIV_A      = 15,
  parameter int HIGH_A     = 5,
  parameter int DIV_B      = 9,
  parameter int HIGH_B     = 3,
  parameter int RESET_HOLD = 255,
  parameter int CNT_W      = 5
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic cpu_reset_req,
  input  logic div_sel,
`ifdef CPU_CLKGEN_STEP_EN
  input  logic clk_hold,
`endif
  output logic CPU_CLK,
  output logic CPU_RESET,
  output logic clk_rise_tick,
  output logic clk_fall_tick,
  output logic div_active
);
  localparam int HOLD_W = $clog2(RESET_HOLD + 1);

  if (DIV_A < 2 || DIV_B < 2) begin : g_err_div
    $error("cpu_clkgen_multi: DIV_A and DIV_B must be >= 2");
  end
  if (HIGH_A < 1 || HIGH_A >= DIV_A || HIGH_B < 1 || HIGH_B >= DIV_B) begin : g_err_high
    $error("cpu_clkgen_multi: HIGH_x must lie in 1..DIV_x-1");
  end
  if (RESET_HOLD < 1) begin : g_err_hold
    $error("cpu_clkgen_multi: RESET_HOLD must be >= 1");
  end
  if ((2 ** CNT_W) < DIV_A || (2 ** CNT_W) < DIV_B) begin : g_err_cnt
    $error("cpu_clkgen_multi: CNT_W too small for DIV_A/DIV_B");
  end

  logic [CNT_W-1:0]  r_p;
  logic [HOLD_W-1:0] r_hold;
  logic              r_div, r_clk, r_rst, r_rise, r_fall, r_frozen;
  logic [CNT_W-1:0]  w_div_m1, w_high;
  logic              w_wrap, w_at_high, w_freeze;

  assign w_div_m1  = r_div ? CNT_W'(DIV_B - 1) : CNT_W'(DIV_A - 1);
  assign w_high    = r_div ? CNT_W'(HIGH_B)    : CNT_W'(HIGH_A);
  assign w_wrap    = (r_p == w_div_m1);
  assign w_at_high = (r_p == w_high);

`ifdef CPU_CLKGEN_STEP_EN
  assign w_freeze = clk_hold & w_at_high;
`else
  assign w_freeze = 1'b0;
`endif

  // Ratio only changes on the wrap edge, so the old low phase always completes.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_p      <= '0;
      r_div    <= 1'b0;
      r_clk    <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_frozen <= 1'b0;
    end else begin
      if (!w_freeze) begin
        if (w_wrap) begin
          r_p   <= '0;
          r_div <= div_sel;
        end else begin
          r_p <= r_p + CNT_W'(1);
        end
      end
      r_frozen <= w_freeze;
      r_clk    <= (r_p < w_high);
      r_rise   <= (r_p == '0);
      // The first frozen cycle is the real falling edge; repeats are suppressed.
      r_fall   <= w_at_high & ~r_frozen;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rst  <= 1'b1;
      r_hold <= '0;
    end else if (cpu_reset_req) begin
      r_rst  <= 1'b1;
      r_hold <= '0;
    end else if (r_rst && r_rise) begin
      if (r_hold == HOLD_W'(RESET_HOLD - 1)) r_rst <= 1'b0;
      r_hold <= r_hold + HOLD_W'(1);
    end
  end

  assign CPU_CLK       = r_clk;
  assign CPU_RESET     = r_rst;
  assign clk_rise_tick = r_rise;
  assign clk_fall_tick = r_fall;
  assign div_active    = r_div;
endmodule

// File: tb/tb_cpu_clkgen_multi.sv
`timescale 1ns/1ps
// Bench for cpu_clkgen_multi: directed vector table, mid-period reset, then random run vs period-level model.
module tb_cpu_clkgen_multi;
  localparam int DIV_A = 15, HIGH_A = 5, DIV_B = 9, HIGH_B = 3, RESET_HOLD = 4;

  logic aclk = 1'b0;
  logic aresetn, req, sel;
  logic hold = 1'b0;
  logic CPU_CLK, CPU_RESET, rise, fall, dact;

  cpu_clkgen_multi #(
    .DIV_A(DIV_A), .HIGH_A(HIGH_A), .DIV_B(DIV_B), .HIGH_B(HIGH_B),
    .RESET_HOLD(RESET_HOLD), .CNT_W(5)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .cpu_reset_req(req), .div_sel(sel),
`ifdef CPU_CLKGEN_STEP_EN
    .clk_hold(hold),
`endif
    .CPU_CLK(CPU_CLK), .CPU_RESET(CPU_RESET), .clk_rise_tick(rise),
    .clk_fall_tick(fall), .div_active(dact)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b want %0b at %0t", name, act, exp, $time);
  endtask

  // Reference model: whole periods are expanded into a queue of per-cycle outputs.
  typedef struct packed { logic clk; logic rise; logic fall; } ph_t;
  ph_t q[$];
  ph_t m_out;
  bit  m_div, m_rst, m_frz;
  int  m_cnt;

  task automatic model_reset();
    q.delete();
    m_out = '0; m_div = 0; m_rst = 1; m_frz = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    bit prev_rise = m_out.rise;
    int d, h;
    ph_t e;
    if (req) begin
      m_rst = 1; m_cnt = 0;
    end else if (m_rst && prev_rise) begin
      m_cnt++;
      if (m_cnt == RESET_HOLD) m_rst = 0;
    end
    if (q.size() == 0) begin
      d = m_div ? DIV_B : DIV_A;
      h = m_div ? HIGH_B : HIGH_A;
      for (int j = 0; j < d; j++) begin
        e.clk = (j < h); e.rise = (j == 0); e.fall = (j == h);
        q.push_back(e);
      end
    end
    if (q[0].fall && hold) begin
      m_out.clk = 0; m_out.rise = 0; m_out.fall = !m_frz;
      m_frz = 1;
    end else begin
      m_out = q.pop_front();
      if (m_out.fall && m_frz) m_out.fall = 0;
      m_frz = 0;
      if (q.size() == 0) m_div = sel;
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
    model_edge();
  endtask

  typedef struct {
    logic req; logic sel; int adv;
    logic clk; logic rst; logic div; logic rise; logic fall;
  } vec_t;
  vec_t tbl[16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // {req, sel, edges to advance, exp CPU_CLK, CPU_RESET, div_active, rise, fall}
    tbl[0]  = '{1'b1, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 14, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 56, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 5,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 2,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 4,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    aresetn = 1'b0; req = 1'b1; sel = 1'b0; hold = 1'b0;
    #12;
    chk("rst.clk", CPU_CLK, 1'b0);
    chk("rst.cpu_reset", CPU_RESET, 1'b1);
    chk("rst.div", dact, 1'b0);
    chk("rst.rise", rise, 1'b0);
    chk("rst.fall", fall, 1'b0);
    aresetn = 1'b1;
    model_reset();

    for (int i = 0; i < 16; i++) begin
      req = tbl[i].req; sel = tbl[i].sel;
      repeat (tbl[i].adv) tick();
      chk($sformatf("vec%0d.clk", i), CPU_CLK, tbl[i].clk);
      chk($sformatf("vec%0d.cpu_reset", i), CPU_RESET, tbl[i].rst);
      chk($sformatf("vec%0d.div", i), dact, tbl[i].div);
      chk($sformatf("vec%0d.rise", i), rise, tbl[i].rise);
      chk($sformatf("vec%0d.fall", i), fall, tbl[i].fall);
    end

    // Async reset inside the ratio-B high phase, with div_sel still requesting B.
    aresetn = 1'b0;
    #2;
    chk("midrst.clk", CPU_CLK, 1'b0);
    chk("midrst.cpu_reset", CPU_RESET, 1'b1);
    chk("midrst.div", dact, 1'b0);
    chk("midrst.rise", rise, 1'b0);
    req = 1'b0; sel = 1'b1;
    #2;
    aresetn = 1'b1;
    model_reset();
    tick();
    chk("post.clk", CPU_CLK, 1'b1);
    chk("post.rise", rise, 1'b1);
    chk("post.div", dact, 1'b0);
    repeat (5) tick();
    chk("post.fall_at_highA", fall, 1'b1);
    chk("post.clk_low", CPU_CLK, 1'b0);

    for (int c = 0; c < 1500; c++) begin
      if (req) req = ($urandom_range(0, 3) != 0);
      else     req = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 19) == 0) sel = ~sel;
`ifdef CPU_CLKGEN_STEP_EN
      if ($urandom_range(0, 29) == 0) hold = ~hold;
`endif
      tick();
      chk("rnd.clk", CPU_CLK, m_out.clk);
      chk("rnd.rise", rise, m_out.rise);
      chk("rnd.fall", fall, m_out.fall);
      chk("rnd.cpu_reset", CPU_RESET, m_rst);
      chk("rnd.div", dact, m_div);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
